i2s_tile_mask: RTL and testbench

//  Parametrised successor to the single-panel I2S mask. Oversamples a serial I2S-style pixel stream
//  (i2s_clk/i2s_ws/i2s_data) in the system clock domain. Extracts the row segment addressed by
//  (addr_x, addr_y) from a TILES_X x TILES_Y tiled wall and double-buffers it. Then scans it out to a
//  HUB-style LED panel with CHANNELS parallel data lanes, shift clock, latch and output-enable.

---
 rtl/i2s_tile_mask.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_i2s_tile_mask.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tile_mask.sv
// i2s_tile_mask: tiled-wall I2S pixel capture with HUB LED scan-out.
// Optional feature macro: LED_TEST_PATTERN_EN (test_mode checkerboard).
module i2s_tile_mask #(
  parameter int COLS      = 32,
  parameter int ROWS      = 16,
  parameter int CHANNELS  = 3,
  parameter int TILES_X   = 4,
  parameter int TILES_Y   = 4,
  parameter int ADDR_W    = 4,
  parameter int CLK_DIV   = 2,
  parameter int ON_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i2s_clk,
  input  logic                      i2s_ws,
  input  logic                      i2s_data,
  input  logic [ADDR_W-1:0]         addr_x,
  input  logic [ADDR_W-1:0]         addr_y,
`ifdef LED_TEST_PATTERN_EN
  input  logic                      test_mode,
`endif
  output logic [$clog2(ROWS)-1:0]   row_num,
  output logic [CHANNELS-1:0]       led_data,
  output logic                      led_clk,
  output logic                      led_lat,
  output logic                      led_oe,
  output logic                      overflow
);

  localparam int RW  = $clog2(ROWS);
  localparam int SEG = COLS * CHANNELS;
  localparam int T   = TILES_X * TILES_Y;
  localparam int KW  = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int SW  = (T > 1) ? $clog2(T) : 1;
  localparam int PW  = $clog2(2 * CLK_DIV);
  localparam int OW  = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISP
  } state_t;

  logic [1:0]     r_ck_s;
  logic [1:0]     r_ws_s;
  logic [1:0]     r_d_s;
  logic           r_ck_p;
  logic           r_ws_p;
  logic           r_armed;
  logic           r_hit;
  logic           r_done;
  logic           r_ovf;
  logic [KW-1:0]  r_k;
  logic [SW-1:0]  r_seg;
  logic [RW:0]    r_row;
  logic [RW-1:0]  r_done_row;
  logic [SEG-1:0] r_cap;
  logic [SEG-1:0] r_shf;
  logic [RW-1:0]  r_brow;
  logic [RW-1:0]  r_row_num;
  state_t         r_state;
  state_t         w_next;
  logic [PW-1:0]  r_ph;
  logic [CW-1:0]  r_col;
  logic [OW-1:0]  r_on;

  logic           w_edge;
  logic           w_ws_rise;
  logic           w_row_ok;
  logic           w_go;
  logic [KW-1:0]  w_k;
  logic [SW-1:0]  w_seg;
  logic [RW:0]    w_row;
  int             w_tgt;
  logic           w_inr;
  logic           w_hit;
  logic           w_last_k;
  logic           w_last_seg;
  logic           w_load;
  logic [SEG-1:0] w_src;
  logic [RW-1:0]  w_src_row;
  logic           w_ovf_set;
  logic           w_ph_last;
  logic           w_col_last;
  logic           w_on_last;
  logic [CHANNELS-1:0] w_pix;

  // Two-flop synchronisers for the asynchronous serial inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ck_s <= '0;
      r_ws_s <= '0;
      r_d_s  <= '0;
      r_ck_p <= 1'b0;
    end else begin
      r_ck_s <= {r_ck_s[0], i2s_clk};
      r_ws_s <= {r_ws_s[0], i2s_ws};
      r_d_s  <= {r_d_s[0], i2s_data};
      r_ck_p <= r_ck_s[1];
    end
  end

  assign w_edge    = r_ck_s[1] & ~r_ck_p;
  assign w_ws_rise = w_edge & r_ws_s[1] & ~r_ws_p;
  assign w_row_ok  = r_row < (RW+1)'(ROWS);
  assign w_go      = w_ws_rise |
                     (w_edge & r_armed & w_row_ok);

  // A frame marker forces the current bit to bit 0 of row 0.
  assign w_k   = w_ws_rise ? '0 : r_k;
  assign w_seg = w_ws_rise ? '0 : r_seg;
  assign w_row = w_ws_rise ? '0 : r_row;

  assign w_tgt = int'(addr_y) * TILES_X + int'(addr_x);
  assign w_inr = (int'(addr_x) < TILES_X) &&
                 (int'(addr_y) < TILES_Y);

  // Tile selection is re-evaluated only at segment starts.
  assign w_hit = (w_k == '0) ?
                 (w_inr && (int'(w_seg) == w_tgt)) :
                 r_hit;

  assign w_last_k   = w_k == KW'(SEG - 1);
  assign w_last_seg = w_seg == SW'(T - 1);

  // Stream position tracking and capture of the addressed segment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ws_p     <= 1'b0;
      r_armed    <= 1'b0;
      r_hit      <= 1'b0;
      r_done     <= 1'b0;
      r_k        <= '0;
      r_seg      <= '0;
      r_row      <= '0;
      r_done_row <= '0;
      r_cap      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_edge) begin
        r_ws_p <= r_ws_s[1];
      end
      if (w_go) begin
        r_armed    <= 1'b1;
        r_hit      <= w_hit;
        r_done     <= w_hit & w_last_k;
        r_done_row <= w_row[RW-1:0];
        if (w_hit) begin
          r_cap[w_k] <= r_d_s[1];
        end
        if (w_last_k) begin
          r_k <= '0;
          if (w_last_seg) begin
            r_seg <= '0;
            r_row <= w_row + 1'b1;
          end else begin
            r_seg <= w_seg + 1'b1;
            r_row <= w_row;
          end
        end else begin
          r_k   <= w_k + 1'b1;
          r_seg <= w_seg;
          r_row <= w_row;
        end
      end
    end
  end

`ifdef LED_TEST_PATTERN_EN
  logic [RW-1:0]  r_trow;
  logic [SEG-1:0] w_pat;

  // Checkerboard row for the current test row.
  always_comb begin
    w_pat = '0;
    for (int c = 0; c < COLS; c++) begin
      w_pat[c*CHANNELS +: CHANNELS] =
        {CHANNELS{c[0] ^ r_trow[0]}};
    end
  end

  // Free-running test row counter, advanced per loaded row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trow <= '0;
    end else if (w_load && test_mode) begin
      if (r_trow == RW'(ROWS - 1)) begin
        r_trow <= '0;
      end else begin
        r_trow <= r_trow + 1'b1;
      end
    end
  end

  assign w_load    = (r_state == S_IDLE) &
                     (test_mode | r_done);
  assign w_src     = test_mode ? w_pat : r_cap;
  assign w_src_row = test_mode ? r_trow : r_done_row;
  assign w_ovf_set = r_done & ~test_mode &
                     (r_state != S_IDLE);
`else
  assign w_load    = (r_state == S_IDLE) & r_done;
  assign w_src     = r_cap;
  assign w_src_row = r_done_row;
  assign w_ovf_set = r_done & (r_state != S_IDLE);
`endif

  assign w_ph_last  = r_ph == PW'(2 * CLK_DIV - 1);
  assign w_col_last = r_col == CW'(COLS - 1);
  assign w_on_last  = r_on == OW'(ON_CYCLES - 1);
  assign w_pix = r_shf[int'(r_col)*CHANNELS +: CHANNELS];

  // Scanner state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Scanner next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load) w_next = S_SHIFT;
      S_SHIFT: if (w_ph_last && w_col_last)
                 w_next = S_BLANK;
      S_BLANK: w_next = S_LATCH;
      S_LATCH: w_next = S_DISP;
      S_DISP:  if (w_on_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shift buffer, scan counters, displayed row and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shf     <= '0;
      r_brow    <= '0;
      r_row_num <= '0;
      r_ph      <= '0;
      r_col     <= '0;
      r_on      <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
      if (w_load) begin
        r_shf  <= w_src;
        r_brow <= w_src_row;
      end
      if (r_state == S_BLANK) begin
        r_row_num <= r_brow;
      end
      if (r_state == S_SHIFT) begin
        if (w_ph_last) begin
          r_ph  <= '0;
          r_col <= r_col + 1'b1;
        end else begin
          r_ph <= r_ph + 1'b1;
        end
      end else begin
        r_ph  <= '0;
        r_col <= '0;
      end
      if (r_state == S_DISP) begin
        r_on <= r_on + 1'b1;
      end else begin
        r_on <= '0;
      end
    end
  end

  // Panel outputs decoded from scanner state.
  always_comb begin
    led_data = '0;
    led_clk  = 1'b0;
    led_lat  = 1'b0;
    led_oe   = 1'b1;
    unique case (r_state)
      S_SHIFT: begin
        led_data = w_pix;
        led_clk  = r_ph >= PW'(CLK_DIV);
      end
      S_LATCH: led_lat = 1'b1;
      S_DISP:  led_oe  = 1'b0;
      default: ;
    endcase
  end

  assign row_num  = r_row_num;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_i2s_tile_mask.sv
// tb_i2s_tile_mask: scoreboard bench for i2s_tile_mask.
// Instance a: 2x2 wall, default scan; instance b: 1x1 wall, slow scan.
module tb_i2s_tile_mask;

  localparam int SEG  = 96;
  localparam int COLS = 32;
  localparam int ON   = 64;

  typedef struct {
    logic [3:0]     row;
    logic [SEG-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_ck = 1'b0, a_ws = 1'b0, a_d = 1'b0;
  logic b_ck = 1'b0, b_ws = 1'b0, b_d = 1'b0;
  logic [3:0] ax = 4'd0, ay = 4'd0;
  logic [3:0] bx = 4'd0, by = 4'd0;
`ifdef LED_TEST_PATTERN_EN
  logic tm = 1'b0;
  logic tm_b = 1'b0;
`endif

  logic [3:0] a_row, b_row;
  logic [2:0] a_data, b_data;
  logic a_lclk, a_lat, a_oe, a_ovf;
  logic b_lclk, b_lat, b_oe, b_ovf;

  int total = 0;
  int bad = 0;
  int lat_cnt = 0;
  int oe_low = 0;
  int b_lat_cnt = 0;
  logic [3:0] b_lat_row = 4'd0;
  exp_t q[$];

  always #5 clk = ~clk;

  i2s_tile_mask #(
    .TILES_X(2), .TILES_Y(2)
  ) u_a (
    .clk(clk), .rst(rst),
    .i2s_clk(a_ck), .i2s_ws(a_ws), .i2s_data(a_d),
    .addr_x(ax), .addr_y(ay),
`ifdef LED_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .row_num(a_row), .led_data(a_data),
    .led_clk(a_lclk), .led_lat(a_lat),
    .led_oe(a_oe), .overflow(a_ovf)
  );

  i2s_tile_mask #(
    .TILES_X(1), .TILES_Y(1), .CLK_DIV(64)
  ) u_b (
    .clk(clk), .rst(rst),
    .i2s_clk(b_ck), .i2s_ws(b_ws), .i2s_data(b_d),
    .addr_x(bx), .addr_y(by),
`ifdef LED_TEST_PATTERN_EN
    .test_mode(tm_b),
`endif
    .row_num(b_row), .led_data(b_data),
    .led_clk(b_lclk), .led_lat(b_lat),
    .led_oe(b_oe), .overflow(b_ovf)
  );

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [SEG-1:0] pat(input int r);
    logic [SEG-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*3 +: 3] = 3'(c + r);
    return v;
  endfunction

  task automatic push(input int r, input logic [SEG-1:0] d);
    exp_t e;
    e.row = 4'(r);
    e.data = d;
    q.push_back(e);
  endtask

  task automatic send_bit(input int sel, input logic b,
                          input logic w);
    if (sel == 0) begin
      a_ck = 1'b0; a_d = b; a_ws = w;
    end else begin
      b_ck = 1'b0; b_d = b; b_ws = w;
    end
    repeat (2) @(negedge clk);
    if (sel == 0) a_ck = 1'b1;
    else b_ck = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bits(input int sel, input logic first,
                           input int hit,
                           input logic [SEG-1:0] hv,
                           input logic [SEG-1:0] ov,
                           input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int s, k;
      logic b;
      s = i / SEG;
      k = i % SEG;
      b = (s == hit) ? hv[k] : ov[k];
      send_bit(sel, b, first && (i == 0));
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (q.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    repeat (250) @(negedge clk);
    check("drain_queue", q.size(), 0);
  endtask

  // Monitor for instance a: collects shifted pixels, checks on latch.
  initial begin
    int pulses;
    int oe_run;
    logic pclk;
    logic [SEG-1:0] cap;
    exp_t e;
    pulses = 0; oe_run = 0; pclk = 1'b0; cap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pulses = 0; oe_run = 0; pclk = 1'b0; cap = '0;
      end else begin
        if (a_lclk && !pclk) begin
          if (pulses < COLS) cap[pulses*3 +: 3] = a_data;
          pulses++;
        end
        pclk = a_lclk;
        if (a_lat) begin
          lat_cnt++;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_latch: row_num=%0d, required none",
                     a_row);
          end else begin
            e = q.pop_front();
            check("lat_row_num", a_row, e.row);
            check("lat_row_data", cap, e.data);
            check("lat_clk_pulses", pulses, COLS);
            check("lat_led_data_zero", a_data, 0);
          end
          pulses = 0;
          cap = '0;
        end
        if (!a_oe) begin
          oe_run++;
          oe_low++;
        end else if (oe_run > 0) begin
          check("oe_low_cycles", oe_run, ON);
          oe_run = 0;
        end
      end
    end
  end

  // Latch counter for instance b.
  initial begin
    forever begin
      @(negedge clk);
      if (b_lat) begin
        b_lat_cnt++;
        b_lat_row = b_row;
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i, l0, o0, bl0;
    logic [SEG-1:0] p0;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_row_num", a_row, 0);
    check("rst_led_data", a_data, 0);
    check("rst_led_clk", a_lclk, 0);
    check("rst_led_lat", a_lat, 0);
    check("rst_led_oe", a_oe, 1);
    check("rst_overflow", a_ovf, 0);

    // reset during shift
    ax = 4'd1; ay = 4'd0;
    send_bits(0, 1'b1, 1, '1, '0, 192);
    i = 0;
    while (!a_lclk && i < 400) begin
      @(negedge clk);
      i++;
    end
    check("t1_shift_seen", a_lclk, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t1_led_oe", a_oe, 1);
    check("t1_led_clk", a_lclk, 0);
    check("t1_led_lat", a_lat, 0);
    check("t1_row_num", a_row, 0);
    check("t1_overflow", a_ovf, 0);
    check("t1_led_data", a_data, 0);

    // single row, addressed segment all ones
    push(0, '1);
    send_bits(0, 1'b1, 1, '1, '0, 384);
    drain(2000);

    // sixteen rows plus one ignored row
    for (int r = 0; r < 16; r++) push(r, pat(r));
    for (int r = 0; r < 17; r++)
      send_bits(0, r == 0, 1, pat(r), ~pat(r), 384);
    drain(2000);

    // frame restart in the middle of row 3
    for (int r = 0; r < 3; r++) push(r, pat(r + 5));
    push(0, pat(9));
    for (int r = 0; r < 3; r++)
      send_bits(0, r == 0, 1, pat(r + 5), ~pat(r + 5), 384);
    send_bits(0, 1'b0, 1, pat(8), ~pat(8), 100);
    send_bits(0, 1'b1, 1, pat(9), ~pat(9), 384);
    drain(2000);

    // out-of-range tile column
    l0 = lat_cnt;
    o0 = oe_low;
    ax = 4'd4; ay = 4'd0;
    for (int r = 0; r < 16; r++)
      send_bits(0, r == 0, 1, '1, '1, 384);
    repeat (300) @(negedge clk);
    check("t6_no_latch", lat_cnt, l0);
    check("t6_no_oe_low", oe_low, o0);
    check("t6_led_oe", a_oe, 1);

    // overflow on slow scanner
    bl0 = b_lat_cnt;
    send_bits(1, 1'b1, 0, '1, '0, 96);
    repeat (10) @(negedge clk);
    check("t4_ovf_after_row0", b_ovf, 0);
    send_bits(1, 1'b0, 0, pat(1), '0, 96);
    repeat (10) @(negedge clk);
    check("t4_ovf_after_row1", b_ovf, 1);
    send_bits(1, 1'b0, 0, pat(2), '0, 96);
    repeat (10) @(negedge clk);
    check("t4_ovf_after_row2", b_ovf, 1);
    i = 0;
    while (b_lat_cnt == bl0 && i < 6000) begin
      @(negedge clk);
      i++;
    end
    check("t4_latch_count", b_lat_cnt - bl0, 1);
    check("t4_latch_row", b_lat_row, 0);
    repeat (300) @(negedge clk);
    check("t4_latch_count_final", b_lat_cnt - bl0, 1);
    check("t4_ovf_sticky", b_ovf, 1);
    check("t4_led_oe_idle", b_oe, 1);
    check("t4_led_clk_idle", b_lclk, 0);
    check("t4_led_data_idle", b_data, 0);

`ifdef LED_TEST_PATTERN_EN
    // checkerboard generator
    p0 = {16{6'b111000}};
    push(0, p0);
    push(1, ~p0);
    l0 = lat_cnt;
    tm = 1'b1;
    i = 0;
    while (lat_cnt < l0 + 2 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    tm = 1'b0;
    check("t7_two_latches", lat_cnt - l0, 2);
    drain(2000);
`else
    p0 = '0;
`endif

    drain(2000);
    check("a_overflow_clear", a_ovf, 0);
    check("a_latch_total_nonzero", (lat_cnt > 0) ? p0[0] | 1'b1 : 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
